// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: diff = a - b, LSB first, one bit per clock,
// with a start/busy/done handshake and a registered borrow chained between bits.
module serial_subtractor #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic             br;
    logic [CW-1:0]    cnt;

    logic ai;
    logic bi;
    logic d;
    logic br_next;

    always_comb begin
        ai      = a_sr[0];
        bi      = b_sr[0];
        d       = ai ^ bi ^ br;
        br_next = (~ai & bi) | (~(ai ^ bi) & br);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            diff       <= '0;
            borrow_out <= 1'b0;
            br         <= 1'b0;
            cnt        <= '0;
            a_sr       <= '0;
            b_sr       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sr  <= a;
                        b_sr  <= b;
                        br    <= 1'b0;
                        cnt   <= '0;
                        diff  <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    // Result bits enter at the MSB so bit 0 holds the LSB after WIDTH shifts.
                    diff <= {d, diff[WIDTH-1:1]};
                    a_sr <= a_sr >> 1;
                    b_sr <= b_sr >> 1;
                    br   <= br_next;
                    cnt  <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        borrow_out <= br_next;
                        done       <= 1'b1;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and randomised checks of serial_subtractor at WIDTH=8 and WIDTH=16.
module tb_serial_subtractor;

    logic        clk = 1'b0;
    logic        rst;
    logic        start8;
    logic [7:0]  a8, b8;
    logic        busy8, done8, bo8;
    logic [7:0]  diff8;
    logic        start16;
    logic [15:0] a16, b16;
    logic        busy16, done16, bo16;
    logic [15:0] diff16;

    int unsigned checks = 0;
    int unsigned errors = 0;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .diff(diff8), .borrow_out(bo8)
    );

    serial_subtractor #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .a(a16), .b(b16),
        .busy(busy16), .done(done16), .diff(diff16), .borrow_out(bo16)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
    task automatic run8(input string tag, input logic [7:0] av, input logic [7:0] bv,
                        input logic [7:0] ed, input logic eb);
        int unsigned lat;
        logic seen;
        a8 = av; b8 = bv; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0; a8 = ~av; b8 = 8'($urandom);
        seen = 1'b0; lat = 0;
        for (int unsigned n = 1; n <= 40 && !seen; n++) begin
            @(negedge clk);
            if (done8) begin seen = 1'b1; lat = n - 1; end
        end
        if (!seen) begin
            check({tag, "_timeout"}, 32'(seen), 32'd1);
        end else begin
            check({tag, "_latency"}, lat, 32'd8);
            check({tag, "_diff"}, 32'(diff8), 32'(ed));
            check({tag, "_borrow"}, 32'(bo8), 32'(eb));
            check({tag, "_busy_in_done"}, 32'(busy8), 32'd1);
            @(negedge clk);
            check({tag, "_done_single"}, 32'(done8), 32'd0);
            check({tag, "_busy_fall"}, 32'(busy8), 32'd0);
        end
    endtask

    task automatic run16(input string tag, input logic [15:0] av, input logic [15:0] bv,
                         input logic [15:0] ed, input logic eb);
        int unsigned lat;
        logic seen;
        a16 = av; b16 = bv; start16 = 1'b1;
        @(posedge clk); #1;
        start16 = 1'b0; a16 = ~av; b16 = 16'($urandom);
        seen = 1'b0; lat = 0;
        for (int unsigned n = 1; n <= 60 && !seen; n++) begin
            @(negedge clk);
            if (done16) begin seen = 1'b1; lat = n - 1; end
        end
        if (!seen) begin
            check({tag, "_timeout"}, 32'(seen), 32'd1);
        end else begin
            check({tag, "_latency"}, lat, 32'd16);
            check({tag, "_diff"}, 32'(diff16), 32'(ed));
            check({tag, "_borrow"}, 32'(bo16), 32'(eb));
            @(negedge clk);
            check({tag, "_done_single"}, 32'(done16), 32'd0);
            check({tag, "_busy_fall"}, 32'(busy16), 32'd0);
        end
    endtask

    initial begin
        logic [7:0]  ra8, rb8, ea8, eb8;
        logic [15:0] ra16, rb16;
        logic        seen;

        rst = 1'b1; start8 = 1'b0; a8 = '0; b8 = '0;
        start16 = 1'b0; a16 = '0; b16 = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 32'(busy8), 32'd0);
        check("rst_done", 32'(done8), 32'd0);
        check("rst_diff", 32'(diff8), 32'h00);
        check("rst_borrow", 32'(bo8), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        run8("v35m12", 8'h35, 8'h12, 8'h23, 1'b0);
        run8("v12m35", 8'h12, 8'h35, 8'hDD, 1'b1);
        run8("v00m01", 8'h00, 8'h01, 8'hFF, 1'b1);
        run8("vFFmFF", 8'hFF, 8'hFF, 8'h00, 1'b0);
        run8("v80m7F", 8'h80, 8'h7F, 8'h01, 1'b0);

        // Start held high, operands change every cycle; accepts land at cycles 0, 10, 20.
        for (int unsigned i = 0; i < 30; i++) begin
            a8 = 8'(i * 7 + 3); b8 = 8'(i * 29 + 5); start8 = 1'b1;
            @(posedge clk);
            @(negedge clk);
            if (i % 10 == 8) begin
                ea8 = 8'((i - 8) * 7 + 3);
                eb8 = 8'((i - 8) * 29 + 5);
                check("b2b_done", 32'(done8), 32'd1);
                check("b2b_diff", 32'(diff8), 32'(8'(ea8 - eb8)));
                check("b2b_borrow", 32'(bo8), 32'(ea8 < eb8));
            end else begin
                check("b2b_no_done", 32'(done8), 32'd0);
            end
        end
        start8 = 1'b0;
        @(negedge clk);
        check("b2b_idle", 32'(busy8), 32'd0);

        // Reset in the middle of RUN abandons the operation; borrow_out was 1 beforehand.
        run8("pre_rst", 8'h00, 8'h01, 8'hFF, 1'b1);
        a8 = 8'h35; b8 = 8'h12; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", 32'(busy8), 32'd0);
        check("abort_done", 32'(done8), 32'd0);
        check("abort_diff", 32'(diff8), 32'h00);
        check("abort_borrow", 32'(bo8), 32'd0);
        seen = 1'b0;
        for (int unsigned n = 0; n < 12; n++) begin
            @(negedge clk);
            if (done8 || busy8) seen = 1'b1;
        end
        check("abort_no_done", 32'(seen), 32'd0);
        run8("v10m01", 8'h10, 8'h01, 8'h0F, 1'b0);

        run16("w16_a", 16'h1234, 16'h0235, 16'h0FFF, 1'b0);
        run16("w16_b", 16'h0000, 16'h0001, 16'hFFFF, 1'b1);

        for (int unsigned i = 0; i < 1000; i++) begin
            ra8 = 8'($urandom); rb8 = 8'($urandom);
            run8("rnd8", ra8, rb8, 8'(ra8 - rb8), ra8 < rb8);
        end
        for (int unsigned i = 0; i < 1000; i++) begin
            ra16 = 16'($urandom); rb16 = 16'($urandom);
            run16("rnd16", ra16, rb16, 16'(ra16 - rb16), ra16 < rb16);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
